// File: rtl/hann_windower.sv
// Hann windowing stage: streams one analysis window from the ring buffer,
// scales each sample by a Q0.16 ROM coefficient and writes it to the output buffer.
module hann_windower #(
    parameter int RING_ADDR_W = 13,
    parameter int WIN_LOG2    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go_in,
    input  logic [1:0]             window_start,
    output logic [RING_ADDR_W-1:0] ring_buf_rd_addr,
    input  logic [15:0]            ring_buf_rd_data,
    output logic [WIN_LOG2-1:0]    coef_addr,
    input  logic [15:0]            coef_data,
    output logic [WIN_LOG2-1:0]    out_buf_addr,
    output logic [15:0]            out_buf_data,
    output logic                   out_buf_wren,
    output logic                   busy,
    output logic                   go_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [RING_ADDR_W-1:0] base_q, base_d;
    logic [WIN_LOG2-1:0]    idx_q, idx_d;
    logic [RING_ADDR_W-1:0] ring_addr_q, ring_addr_d;
    logic [WIN_LOG2-1:0]    coef_addr_q, coef_addr_d;
    logic [1:0]             vld_pipe_q, vld_pipe_d;
    logic [WIN_LOG2-1:0]    tag1_q, tag1_d;
    logic [WIN_LOG2-1:0]    out_addr_q, out_addr_d;
    logic [15:0]            out_data_q, out_data_d;
    logic                   wren_q, wren_d;
    logic                   busy_q, busy_d;
    logic                   go_out_q, go_out_d;

    logic signed [31:0]     samp_x, coef_x, prod;

    // Full product fits in 32 bits signed: |-32768 * 65535| < 2^31.
    always_comb begin
        samp_x = 32'($signed(ring_buf_rd_data));
        coef_x = $signed(32'(coef_data));
        prod   = samp_x * coef_x;
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        ring_addr_d = ring_addr_q;
        coef_addr_d = coef_addr_q;
        busy_d      = busy_q;
        go_out_d    = go_out_q;
        // Stage 0 tag is the coefficient address itself; stage 1 carries it on.
        vld_pipe_d  = {vld_pipe_q[0], 1'b0};
        tag1_d      = coef_addr_q;
        wren_d      = vld_pipe_q[1];
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        if (vld_pipe_q[1]) begin
            out_addr_d = tag1_q;
            out_data_d = 16'(prod >>> 16);
        end

        case (state_q)
            IDLE: begin
                if (go_in) begin
                    base_d   = {window_start, {(RING_ADDR_W-2){1'b0}}};
                    go_out_d = 1'b0;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                ring_addr_d   = base_q + RING_ADDR_W'(idx_q);
                coef_addr_d   = idx_q;
                vld_pipe_d[0] = 1'b1;
                idx_d         = idx_q + 1'b1;
                if (idx_q == '1) state_d = DRAIN;
            end
            DRAIN: begin
                // Last sample is in stage 1; it is written on the next edge.
                if (vld_pipe_q[1] && tag1_q == '1) state_d = DONE;
            end
            DONE: begin
                busy_d   = 1'b0;
                go_out_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            idx_q       <= '0;
            ring_addr_q <= '0;
            coef_addr_q <= '0;
            vld_pipe_q  <= '0;
            tag1_q      <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
            go_out_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            ring_addr_q <= ring_addr_d;
            coef_addr_q <= coef_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            tag1_q      <= tag1_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            wren_q      <= wren_d;
            busy_q      <= busy_d;
            go_out_q    <= go_out_d;
        end
    end

    assign ring_buf_rd_addr = ring_addr_q;
    assign coef_addr        = coef_addr_q;
    assign out_buf_addr     = out_addr_q;
    assign out_buf_data     = out_data_q;
    assign out_buf_wren     = wren_q;
    assign busy             = busy_q;
    assign go_out           = go_out_q;

endmodule

// File: tb/tb_hann_windower.sv
// Bench for hann_windower: cycle-level window model plus directed literal checks.
module tb_hann_windower;

    localparam int RW = 13;
    localparam int NL = 12;
    localparam int N  = 4096;
    localparam int RS = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic          go_in;
    logic [1:0]    window_start;
    logic [RW-1:0] ring_buf_rd_addr;
    logic [15:0]   ring_buf_rd_data;
    logic [NL-1:0] coef_addr;
    logic [15:0]   coef_data;
    logic [NL-1:0] out_buf_addr;
    logic [15:0]   out_buf_data;
    logic          out_buf_wren;
    logic          busy;
    logic          go_out;

    always #5 clk = ~clk;

    logic [15:0] ring_mem [RS];
    logic [15:0] coef_mem [N];

    always @(posedge clk) begin
        ring_buf_rd_data <= ring_mem[ring_buf_rd_addr];
        coef_data        <= coef_mem[coef_addr];
    end

    hann_windower #(.RING_ADDR_W(RW), .WIN_LOG2(NL)) dut (
        .clk(clk), .reset(reset), .go_in(go_in), .window_start(window_start),
        .ring_buf_rd_addr(ring_buf_rd_addr), .ring_buf_rd_data(ring_buf_rd_data),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .out_buf_addr(out_buf_addr), .out_buf_data(out_buf_data),
        .out_buf_wren(out_buf_wren), .busy(busy), .go_out(go_out)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int floor_div16(input longint p);
        longint q;
        q = p / 65536;
        if (p < 0 && q * 65536 != p) q = q - 1;
        return int'(q);
    endfunction

    // Behavioural model: windows are accepted from idle, each produces N writes
    // at fixed offsets from acceptance, done N+3 edges after acceptance.
    typedef struct {int cyc; int addr; int data;} wr_t;
    wr_t expq[$];
    int  cyc = 0;
    bit  m_active = 0, m_go = 0, m_rst = 0;
    int  m_acc = 0, m_base = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        m_rst = (reset === 1'b1);
        if (m_rst) begin
            m_active = 0;
            m_go     = 0;
            expq.delete();
        end else if (m_active) begin
            if (cyc == m_acc + N + 3) begin
                m_active = 0;
                m_go     = 1;
            end
        end else if (go_in === 1'b1) begin
            m_go     = 0;
            m_active = 1;
            m_acc    = cyc;
            m_base   = int'(window_start) * (RS / 4);
            for (int i = 0; i < N; i++) begin
                wr_t w;
                w.cyc  = m_acc + 3 + i;
                w.addr = i;
                w.data = floor_div16(longint'($signed(ring_mem[(m_base + i) % RS]))
                                     * longint'(coef_mem[i]));
                expq.push_back(w);
            end
        end
    end

    int cap [N];
    int dut_wr = 0;
    int go_rises = 0;
    int last_rise = 0;
    int rise_q[$];
    int go_len[$];
    logic prev_go = 1'b0;

    initial forever begin
        bit exp_wr;
        @(negedge clk);
        if (cyc > 0) begin
            chk("busy", busy, m_active);
            chk("go_out", go_out, m_go);
            exp_wr = (expq.size() > 0 && expq[0].cyc == cyc);
            chk("wren", out_buf_wren, exp_wr);
            if (out_buf_wren === 1'b1) dut_wr++;
            if (exp_wr) begin
                chk("out_addr", out_buf_addr, expq[0].addr);
                chk("out_data", $signed(out_buf_data), expq[0].data);
                cap[expq[0].addr] = int'($signed(out_buf_data));
                void'(expq.pop_front());
            end
            if (m_rst) begin
                chk("rst_ring_addr", ring_buf_rd_addr, 0);
                chk("rst_coef_addr", coef_addr, 0);
                chk("rst_out_addr", out_buf_addr, 0);
                chk("rst_out_data", out_buf_data, 0);
            end else if (m_active && cyc >= m_acc + 1 && cyc <= m_acc + N) begin
                chk("ring_addr", ring_buf_rd_addr, (m_base + cyc - m_acc - 1) % RS);
                chk("coef_addr", coef_addr, cyc - m_acc - 1);
            end
            if (go_out === 1'b1 && prev_go !== 1'b1) begin
                go_rises++;
                last_rise = cyc;
                rise_q.push_back(cyc);
            end
            if (go_out !== 1'b1 && prev_go === 1'b1) go_len.push_back(cyc - last_rise);
            prev_go = go_out;
        end
    end

    int acc_edge = 0;

    task automatic pulse(input logic [1:0] ws);
        @(negedge clk);
        go_in = 1'b1;
        window_start = ws;
        acc_edge = cyc + 1;
        @(negedge clk);
        go_in = 1'b0;
    endtask

    task automatic wait_go(input int lim);
        int n = 0;
        while (go_out !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("go_timeout", go_out, 1);
    endtask

    task automatic fill_default();
        for (int k = 0; k < RS; k++) ring_mem[k] = 16'(k);
        for (int k = 0; k < N; k++) coef_mem[k] = 16'hFFFF;
    endtask

    initial begin
        int w0, r0, l0, n;
        reset = 1'b1;
        go_in = 1'b0;
        window_start = 2'd0;
        fill_default();
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_go_out", go_out, 0);
        chk("reset_wren", out_buf_wren, 0);
        reset = 1'b0;
        @(negedge clk);

        // Ramp through near-unity coefficients
        w0 = dut_wr;
        pulse(2'd0);
        wait_go(5000);
        chk("t1_latency", last_rise - acc_edge, 4099);
        repeat (2) @(negedge clk);
        chk("t1_writes", dut_wr - w0, 4096);
        chk("t1_out0", cap[0], 0);
        chk("t1_out1", cap[1], 0);
        chk("t1_out4095", cap[4095], 4094);

        // Arithmetic corners
        ring_mem[0] = 16'hFFFF; coef_mem[0] = 16'd65535;
        ring_mem[1] = 16'd32767; coef_mem[1] = 16'd32768;
        ring_mem[2] = 16'h8000; coef_mem[2] = 16'd65535;
        ring_mem[3] = 16'd0;     coef_mem[3] = 16'd1234;
        pulse(2'd0);
        wait_go(5000);
        repeat (2) @(negedge clk);
        chk("c_neg1", cap[0], -1);
        chk("c_half", cap[1], 16383);
        chk("c_min", cap[2], -32768);
        chk("c_zero", cap[3], 0);
        fill_default();

        // Wrapping window with an ignored mid-window go_in
        w0 = dut_wr;
        r0 = go_rises;
        pulse(2'd3);
        repeat (99) @(negedge clk);
        go_in = 1'b1;
        window_start = 2'd1;
        @(negedge clk);
        go_in = 1'b0;
        wait_go(5000);
        chk("t3_latency", last_rise - acc_edge, 4099);
        repeat (5) @(negedge clk);
        chk("t3_writes", dut_wr - w0, 4096);
        chk("t3_rises", go_rises - r0, 1);
        chk("t3_out2047", cap[2047], 8190);
        chk("t3_out2048", cap[2048], 0);

        // Reset mid-window aborts, then a fresh window runs
        pulse(2'd0);
        repeat (499) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_go_out", go_out, 0);
        chk("abort_wren", out_buf_wren, 0);
        w0 = dut_wr;
        repeat (50) @(negedge clk);
        chk("abort_no_writes", dut_wr - w0, 0);
        w0 = dut_wr;
        pulse(2'd2);
        wait_go(5000);
        repeat (2) @(negedge clk);
        chk("fresh_writes", dut_wr - w0, 4096);

        // go_in held for three back-to-back windows
        r0 = go_rises;
        w0 = dut_wr;
        @(negedge clk);
        go_in = 1'b1;
        window_start = 2'd1;
        repeat (2) @(negedge clk);
        l0 = go_len.size();
        n = 0;
        while (go_rises < r0 + 3 && n < 13000) begin
            @(negedge clk);
            n++;
        end
        go_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_rises", go_rises - r0, 3);
        chk("held_writes", dut_wr - w0, 3 * 4096);
        chk("held_spacing1", (rise_q.size() > r0 + 1) ? rise_q[r0+1] - rise_q[r0] : -1, 4100);
        chk("held_spacing2", (rise_q.size() > r0 + 2) ? rise_q[r0+2] - rise_q[r0+1] : -1, 4100);
        chk("held_golen1", (go_len.size() > l0) ? go_len[l0] : -1, 1);
        chk("held_golen2", (go_len.size() > l0 + 1) ? go_len[l0+1] : -1, 1);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
